// File: rtl/clock_logic_pkg.sv
// Shared types and defaults for the clock logic node gate sequencer.
package clock_logic_pkg;

  typedef enum logic [2:0] {
    GATED   = 3'd0,
    OPENING = 3'd1,
    OPEN    = 3'd2,
    DRAIN   = 3'd3,
    CLOSING = 3'd4
  } gate_seq_state_t;

  localparam int unsigned DEF_CNT_W                = 8;
  localparam int unsigned DEF_START_SETTLE_CYCLES  = 4;
  localparam int unsigned DEF_STOP_DRAIN_CYCLES    = 2;
  localparam int unsigned DEF_STOP_SETTLE_CYCLES   = 4;

  function automatic logic gate_is_open(input gate_seq_state_t s);
    return (s == OPENING) || (s == OPEN) || (s == DRAIN);
  endfunction

  function automatic logic seq_is_busy(input gate_seq_state_t s);
    return (s == OPENING) || (s == DRAIN) || (s == CLOSING);
  endfunction

endpackage

// File: rtl/clock_logic_settle_counter.sv
// Loadable down-counter shared by the open, drain and close phases.
module clock_logic_settle_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_value_i,
  input  logic             decrement_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  // Saturating at zero keeps the counter from wrapping if a decrement races an exit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_value_i;
    end else if (decrement_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/clock_logic_node_gate_sequencer.sv
// Clock-gate sequencer: timed open/drain/close with started/stopped handshakes.
module clock_logic_node_gate_sequencer
  import clock_logic_pkg::*;
#(
  parameter int unsigned START_SETTLE_CYCLES = DEF_START_SETTLE_CYCLES,
  parameter int unsigned STOP_DRAIN_CYCLES   = DEF_STOP_DRAIN_CYCLES,
  parameter int unsigned STOP_SETTLE_CYCLES  = DEF_STOP_SETTLE_CYCLES,
  parameter int unsigned CNT_W               = DEF_CNT_W
) (
  input  logic clock,
  input  logic async_resetn,
  input  logic internal_request,
  input  logic clock_stopping,
  output logic gate_enable,
  output logic started,
  output logic stopped,
  output logic busy,
  output logic protocol_error
);

  localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(STOP_DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLOSE_LOAD = CNT_W'(STOP_SETTLE_CYCLES - 1);

  gate_seq_state_t  state_q, state_d;
  logic             gate_q, busy_q, err_q;
  logic             err_hit;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;

  clock_logic_settle_counter #(
    .CNT_W (CNT_W)
  ) u_settle_cnt (
    .clk_i        (clock),
    .rst_ni       (async_resetn),
    .load_i       (cnt_load),
    .load_value_i (cnt_load_val),
    .decrement_i  (cnt_dec),
    .zero_o       (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    err_hit      = 1'b0;
    unique case (state_q)
      GATED: begin
        if (clock_stopping) begin
          err_hit = 1'b1;
        end else if (internal_request) begin
          state_d      = OPENING;
          cnt_load     = 1'b1;
          cnt_load_val = START_LOAD;
        end
      end
      OPENING: begin
        err_hit = clock_stopping;
        if (cnt_zero) state_d = OPEN;
        else          cnt_dec = 1'b1;
      end
      OPEN: begin
        if (clock_stopping) begin
          state_d      = DRAIN;
          cnt_load     = 1'b1;
          cnt_load_val = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        err_hit = ~clock_stopping;
        if (cnt_zero) begin
          state_d      = CLOSING;
          cnt_load     = 1'b1;
          cnt_load_val = CLOSE_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      CLOSING: begin
        err_hit = ~clock_stopping;
        if (cnt_zero) state_d = GATED;
        else          cnt_dec = 1'b1;
      end
      default: state_d = GATED;
    endcase
  end

  // Gate and busy are registered from the next state so they track state_q exactly.
  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      state_q <= GATED;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_is_open(state_d);
      busy_q  <= seq_is_busy(state_d);
      err_q   <= err_q | err_hit;
    end
  end

  assign gate_enable    = gate_q;
  assign busy           = busy_q;
  assign protocol_error = err_q;
  assign started        = (state_q == OPENING) && cnt_zero;
  assign stopped        = (state_q == CLOSING) && cnt_zero;

endmodule

// File: tb/tb_clock_logic_node_gate_sequencer.sv
// Directed and randomized checks of the gate sequencer against a timing-offset reference model.
module tb_clock_logic_node_gate_sequencer;

  localparam int S = 4;
  localparam int D = 2;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic req, stop;
  logic gate, started, stopped, busy, perr;
  logic r1, s1;
  logic g1, st1, sp1, b1, e1;

  always #5 clk = ~clk;

  clock_logic_node_gate_sequencer #(
    .START_SETTLE_CYCLES (S),
    .STOP_DRAIN_CYCLES   (D),
    .STOP_SETTLE_CYCLES  (T),
    .CNT_W               (8)
  ) dut (
    .clock            (clk),
    .async_resetn     (rst_n),
    .internal_request (req),
    .clock_stopping   (stop),
    .gate_enable      (gate),
    .started          (started),
    .stopped          (stopped),
    .busy             (busy),
    .protocol_error   (perr)
  );

  clock_logic_node_gate_sequencer #(
    .START_SETTLE_CYCLES (1),
    .STOP_DRAIN_CYCLES   (1),
    .STOP_SETTLE_CYCLES  (1),
    .CNT_W               (4)
  ) dut1 (
    .clock            (clk),
    .async_resetn     (rst_n),
    .internal_request (r1),
    .clock_stopping   (s1),
    .gate_enable      (g1),
    .started          (st1),
    .stopped          (sp1),
    .busy             (b1),
    .protocol_error   (e1)
  );

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;

  // Reference model: phase (0 idle, 1 opening, 2 open, 3 stopping) plus edge it began.
  int   mode = 0;
  int   t0 = 0;
  logic exp_err = 1'b0;
  logic gate_post;

  // Upstream node model: 0 SILENT, 1 STARTING, 2 READY, 3 STOPPING.
  int   node = 0;
  int   stops_done = 0;
  logic p_started = 1'b0;
  logic p_stopped = 1'b0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_step(input int n);
    case (mode)
      0: begin
        if (stop) exp_err = 1'b1;
        else if (req) begin mode = 1; t0 = n; end
      end
      1: begin
        if (stop) exp_err = 1'b1;
        if (n - t0 == S) mode = 2;
      end
      2: if (stop) begin mode = 3; t0 = n; end
      3: begin
        if (!stop) exp_err = 1'b1;
        if (n - t0 == D + T) mode = 0;
      end
      default: mode = 0;
    endcase
  endtask

  task automatic edge_adv();
    @(posedge clk);
    edge_n++;
    if (rst_n) model_step(edge_n);
    #1 gate_post = gate;
  endtask

  task automatic check_cycle();
    int   k;
    logic eg, es, ep, eb;
    @(negedge clk);
    k  = edge_n - t0;
    eg = 1'b0; es = 1'b0; ep = 1'b0; eb = 1'b0;
    case (mode)
      1: begin eg = 1'b1; eb = 1'b1; es = (k == S - 1); end
      2: eg = 1'b1;
      3: begin eg = (k < D); eb = 1'b1; ep = (k == D + T - 1); end
      default: ;
    endcase
    chk("gate_enable", gate, eg);
    chk("started", started, es);
    chk("stopped", stopped, ep);
    chk("busy", busy, eb);
    chk("protocol_error", perr, exp_err);
    chk("gate_stable", gate, gate_post);
  endtask

  task automatic tick(input logic nreq, input logic nstop);
    edge_adv();
    req  = nreq;
    stop = nstop;
    check_cycle();
  endtask

  task automatic node_update();
    case (node)
      0: if ($urandom_range(0, 3) == 0) node = 1;
      1: if (p_started) node = 2;
      2: if ($urandom_range(0, 3) == 0) node = 3;
      3: if (p_stopped) begin node = 0; stops_done++; end
      default: node = 0;
    endcase
    req  = (node != 0);
    stop = (node == 3);
  endtask

  task automatic step1(input logic nr, input logic ns,
                       input logic eg, input logic eb, input logic es, input logic ep);
    @(posedge clk);
    #1 r1 = nr;
    s1 = ns;
    @(negedge clk);
    chk("p1_gate_enable", g1, eg);
    chk("p1_busy", b1, eb);
    chk("p1_started", st1, es);
    chk("p1_stopped", sp1, ep);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    req = 1'b0; stop = 1'b0; r1 = 1'b0; s1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gate_enable", gate, 1'b0);
    chk("rst_started", started, 1'b0);
    chk("rst_stopped", stopped, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_protocol_error", perr, 1'b0);
    chk("rst_p1_gate_enable", g1, 1'b0);
    rst_n = 1'b1;
    edge_n = 0;

    // Directed open driven at edge 10, stop driven at edge 30, released after edge 37.
    for (int e = 1; e <= 9; e++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    for (int e = 11; e <= 29; e++) tick(1'b1, 1'b0);
    for (int e = 30; e <= 36; e++) tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    repeat (3) tick(1'b0, 1'b0);

    // Randomized node traffic: 20 open/close round trips.
    node = 0; stops_done = 0; p_started = 1'b0; p_stopped = 1'b0;
    cyc = 0;
    while (stops_done < 20 && cyc < 4000) begin
      edge_adv();
      node_update();
      check_cycle();
      p_started = started;
      p_stopped = stopped;
      cyc++;
    end
    vectors++;
    assert (stops_done == 20) else begin
      miscompares++;
      $error("FAIL random_budget: completed %0d round trips, required 20", stops_done);
    end
    chk("random_protocol_error", perr, 1'b0);
    req = 1'b0; stop = 1'b0;
    repeat (2) tick(1'b0, 1'b0);

    // Stop asserted during OPENING: sticky error, opening still completes.
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    chk("err_sticky", perr, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);

    // Asynchronous reset mid-DRAIN.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gate_enable", gate, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_started", started, 1'b0);
    chk("arst_stopped", stopped, 1'b0);
    chk("arst_protocol_error", perr, 1'b0);
    mode = 0; exp_err = 1'b0;
    req = 1'b0; stop = 1'b0;
    tick(1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (2) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b1);
    repeat (2) tick(1'b0, 1'b0);

    // All-ones parameterisation: each sequencing phase lasts one cycle.
    r1 = 1'b1;
    step1(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step1(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step1(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step1(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("p1_protocol_error", e1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
